rka_loader: RTL

- Sits between the SPI file downloader and the SDRAM write port.
- Parses an RKA tape image byte stream: optional sync byte, 4-byte header, payload, trailer with checksum.
- Issues one RAM write per payload byte at the addresses the file header names, rather than at raw file offsets.
- Computes the RK checksum, compares it with the file's checksum, and reports start/end address and status so the top level can release reset or jump to start.

---
 rtl/rka_loader.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/rka_loader.sv
// RKA tape image loader: parses sync/header/payload/trailer from the file
// download stream, writes payload bytes to RAM at header-named addresses,
// computes the RK checksum and reports addresses and status.
module rka_loader #(
  parameter logic [15:0] RAM_TOP   = 16'hEBFF,
  parameter bit          SKIP_SYNC = 1'b1,
  parameter int unsigned MAX_GAP   = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        dl_active,
  input  logic        in_wr,
  input  logic [7:0]  in_data,
  output logic        ram_we,
  input  logic        ram_ready,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [2:0]  err_code,
  output logic [15:0] start_addr,
  output logic [15:0] end_addr,
  output logic [15:0] cs_calc,
  output logic        cs_valid
);

  typedef enum logic [3:0] {
    S_IDLE, S_HDR0, S_HDR1, S_HDR2, S_HDR3, S_DATA, S_GAP, S_CSH, S_CSL, S_DONE, S_ERR
  } state_t;

  typedef enum logic [2:0] {
    E_NONE, E_HDR, E_OVR, E_TRUNC, E_TRAIL, E_CSUM
  } err_t;

  localparam logic [7:0] GAP_LIM = 8'(MAX_GAP);

  state_t      state;
  logic        dl_q;
  logic        first_byte;
  logic [15:0] ptr;
  logic [7:0]  gap_cnt;
  logic [7:0]  cs_file_hi;

  logic        rise, fall, byte_ok, hs, overrun, at_end, bad_hdr, cs_match;
  logic [8:0]  lo_sum;
  logic [7:0]  hi_sum;
  logic [15:0] end_full;

  // Edge detection, byte qualification and checksum/header arithmetic
  always_comb begin
    rise     = dl_active & ~dl_q;
    fall     = ~dl_active & dl_q;
    byte_ok  = in_wr & dl_active;
    hs       = ram_we & ram_ready;
    overrun  = byte_ok & ram_we & ~ram_ready;
    at_end   = (ptr == end_addr);
    lo_sum   = {1'b0, cs_calc[7:0]} + {1'b0, in_data};
    hi_sum   = cs_calc[15:8] + in_data + {7'd0, lo_sum[8]};
    end_full = {end_addr[15:8], in_data};
    bad_hdr  = (end_full < start_addr) || (end_full > RAM_TOP);
    cs_match = ({cs_file_hi, in_data} == cs_calc);
  end

  // Parser FSM with registered outputs and RAM write handshake
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      dl_q       <= 1'b0;
      first_byte <= 1'b0;
      ptr        <= '0;
      gap_cnt    <= '0;
      cs_file_hi <= '0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_data   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_code   <= E_NONE;
      start_addr <= '0;
      end_addr   <= '0;
      cs_calc    <= '0;
      cs_valid   <= 1'b0;
    end else begin
      dl_q <= dl_active;
      // A pending write always finishes its handshake, whatever the state.
      if (hs) ram_we <= 1'b0;
      if (rise) begin
        state      <= S_HDR0;
        busy       <= 1'b1;
        done       <= 1'b0;
        error      <= 1'b0;
        err_code   <= E_NONE;
        cs_valid   <= 1'b0;
        cs_calc    <= '0;
        first_byte <= 1'b1;
        gap_cnt    <= '0;
      end else if (busy) begin
        if (overrun) begin
          state    <= S_ERR;
          busy     <= 1'b0;
          error    <= 1'b1;
          err_code <= E_OVR;
        end else if (byte_ok) begin
          case (state)
            S_HDR0: begin
              first_byte <= 1'b0;
              if (!(SKIP_SYNC && first_byte && in_data == 8'hE6)) begin
                start_addr[15:8] <= in_data;
                state            <= S_HDR1;
              end
            end
            S_HDR1: begin
              start_addr[7:0] <= in_data;
              state           <= S_HDR2;
            end
            S_HDR2: begin
              end_addr[15:8] <= in_data;
              state          <= S_HDR3;
            end
            S_HDR3: begin
              end_addr[7:0] <= in_data;
              if (bad_hdr) begin
                state    <= S_ERR;
                busy     <= 1'b0;
                error    <= 1'b1;
                err_code <= E_HDR;
              end else begin
                ptr   <= start_addr;
                state <= S_DATA;
              end
            end
            S_DATA: begin
              ram_addr <= ptr;
              ram_data <= in_data;
              ram_we   <= 1'b1;
              if (at_end) begin
                cs_calc[7:0] <= lo_sum[7:0];
                state        <= S_GAP;
              end else begin
                cs_calc <= {hi_sum, lo_sum[7:0]};
                ptr     <= ptr + 16'd1;
              end
            end
            S_GAP: begin
              if (in_data == 8'h00 && gap_cnt != GAP_LIM) begin
                gap_cnt <= gap_cnt + 8'd1;
              end else if (in_data == 8'hE6) begin
                state <= S_CSH;
              end else begin
                state    <= S_ERR;
                busy     <= 1'b0;
                error    <= 1'b1;
                err_code <= E_TRAIL;
              end
            end
            S_CSH: begin
              cs_file_hi <= in_data;
              state      <= S_CSL;
            end
            S_CSL: begin
              cs_valid <= 1'b1;
              busy     <= 1'b0;
              if (cs_match) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                state    <= S_ERR;
                error    <= 1'b1;
                err_code <= E_CSUM;
              end
            end
            default: ;
          endcase
        end else if (fall) begin
          // Missing trailer is tolerated; a short header or payload is not.
          busy <= 1'b0;
          case (state)
            S_GAP, S_CSH, S_CSL: begin
              state <= S_DONE;
              done  <= 1'b1;
            end
            default: begin
              state    <= S_ERR;
              error    <= 1'b1;
              err_code <= E_TRUNC;
            end
          endcase
        end
      end
    end
  end

endmodule
